// File: rtl/dmem_bytelane.sv
// Byte-lane addressable data memory with sign/zero-extending loads.
// Loads return registered data one cycle after the request; stores write only
// the addressed byte lanes. Misaligned, reserved-size and out-of-range
// accesses are dropped and reported with one-cycle error pulses.
// Optional: define DMEM_CLEAR_ON_RESET_EN to zero the whole array, one word per
// cycle, after every reset release (busy stays high during the sweep).
module dmem_bytelane #(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] address,
  input  logic [31:0]       data_in,
  input  logic              mem_read,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              ld_unsigned,
  output logic [31:0]       data_out,
  output logic              rd_valid,
  output logic              busy,
  output logic              misalign_err,
  output logic              range_err
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W+1)'(4 * DEPTH);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  logic [31:0] mem_q [DEPTH];

  logic [31:0] data_out_q, data_out_d;
  logic        rd_valid_q, rd_valid_d;
  logic        misalign_err_q, misalign_err_d;
  logic        range_err_q, range_err_d;

  logic [IDX_W-1:0] idx_c;
  logic [1:0]       lane_c;
  logic [31:0]      rd_word_c;
  logic [31:0]      load_val_c;
  logic [7:0]       rd_byte_c;
  logic [15:0]      rd_half_c;
  logic             busy_int_c;
  logic             req_c;
  logic             misalign_c;
  logic             range_c;
  logic             clear_we_c;
  logic [IDX_W-1:0] clr_idx_c;
  logic [3:0]       lane_we_c;
  logic [IDX_W-1:0] wr_idx_c;
  logic [31:0]      wr_data_c;

  assign idx_c     = address[IDX_W+1:2];
  assign lane_c    = address[1:0];
  assign rd_word_c = mem_q[idx_c];

`ifdef DMEM_CLEAR_ON_RESET_EN
  typedef enum logic {
    ST_IDLE,
    ST_CLEAR
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] clr_idx_q, clr_idx_d;

  // Clear-sweep state register; every reset restarts the sweep from word 0.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_CLEAR;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  // Sweep sequencing: one zero word per cycle, back to idle after the last word.
  always_comb begin
    state_d    = state_q;
    clr_idx_d  = clr_idx_q;
    clear_we_c = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        clear_we_c = rst;
        clr_idx_d  = clr_idx_q + IDX_W'(1);
        if (clr_idx_q == IDX_W'(DEPTH - 1)) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign clr_idx_c  = clr_idx_q;
  assign busy_int_c = (state_q == ST_CLEAR);
`else
  assign clear_we_c = 1'b0;
  assign clr_idx_c  = '0;
  assign busy_int_c = 1'b0;
`endif

  // Request qualification: drop requests during reset or sweep, then classify.
  always_comb begin
    req_c      = rst & ~busy_int_c & (we | mem_read);
    range_c    = ({1'b0, address} >= ADDR_LIMIT);
    misalign_c = 1'b0;
    case (size)
      SZ_BYTE: misalign_c = 1'b0;
      SZ_HALF: misalign_c = lane_c[0];
      SZ_WORD: misalign_c = (lane_c != 2'b00);
      default: misalign_c = 1'b1;
    endcase
  end

  // Load extraction: pick the addressed lane(s) and extend to 32 bits.
  always_comb begin
    rd_byte_c  = rd_word_c[{lane_c, 3'b000} +: 8];
    rd_half_c  = lane_c[1] ? rd_word_c[31:16] : rd_word_c[15:0];
    load_val_c = rd_word_c;
    case (size)
      SZ_BYTE: load_val_c = ld_unsigned ? {24'h0, rd_byte_c}
                                        : {{24{rd_byte_c[7]}}, rd_byte_c};
      SZ_HALF: load_val_c = ld_unsigned ? {16'h0, rd_half_c}
                                        : {{16{rd_half_c[15]}}, rd_half_c};
      default: load_val_c = rd_word_c;
    endcase
  end

  // Write port: sweep writes win; otherwise an accepted store hits its lanes.
  always_comb begin
    lane_we_c = 4'b0000;
    wr_idx_c  = idx_c;
    wr_data_c = data_in;
    if (clear_we_c) begin
      lane_we_c = 4'b1111;
      wr_idx_c  = clr_idx_c;
      wr_data_c = 32'h0;
    end else if (req_c && we && !misalign_c && !range_c) begin
      case (size)
        SZ_BYTE: begin
          lane_we_c = 4'b0001 << lane_c;
          wr_data_c = {4{data_in[7:0]}};
        end
        SZ_HALF: begin
          lane_we_c = lane_c[1] ? 4'b1100 : 4'b0011;
          wr_data_c = {2{data_in[15:0]}};
        end
        SZ_WORD: begin
          lane_we_c = 4'b1111;
          wr_data_c = data_in;
        end
        default: lane_we_c = 4'b0000;
      endcase
    end
  end

  // Storage array; contents are not reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (lane_we_c[i]) begin
        mem_q[wr_idx_c][8*i +: 8] <= wr_data_c[8*i +: 8];
      end
    end
  end

  // Response next-state: error pulses, load pulse, data_out holds otherwise.
  always_comb begin
    data_out_d     = data_out_q;
    rd_valid_d     = 1'b0;
    misalign_err_d = 1'b0;
    range_err_d    = 1'b0;
    if (req_c) begin
      if (misalign_c) begin
        misalign_err_d = 1'b1;
      end else if (range_c) begin
        range_err_d = 1'b1;
      end else if (mem_read && !we) begin
        rd_valid_d = 1'b1;
        data_out_d = load_val_c;
      end
    end
  end

  // Response registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      data_out_q     <= 32'h0;
      rd_valid_q     <= 1'b0;
      misalign_err_q <= 1'b0;
      range_err_q    <= 1'b0;
    end else begin
      data_out_q     <= data_out_d;
      rd_valid_q     <= rd_valid_d;
      misalign_err_q <= misalign_err_d;
      range_err_q    <= range_err_d;
    end
  end

  assign data_out     = data_out_q;
  assign rd_valid     = rd_valid_q;
  assign misalign_err = misalign_err_q;
  assign range_err    = range_err_q;
  assign busy         = ~rst | busy_int_c;

endmodule
